// File: rtl/uart_rx_oversampled_pkg.sv
// Shared definitions for the oversampled UART receiver and its baud tick
// generator. Defines the frame width, the default line parameters, the
// receiver state encoding, and the tick divider calculation.
package uart_rx_oversampled_pkg;

  localparam int DATA_BITS    = 8;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUDRATE = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_t;

  // Clocks per oversample tick. Integer division truncates, so the bit
  // period can come out slightly short of the nominal baud period.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator. Produces a one-cycle pulse every DIV clocks,
// where DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE). The transmitter can reuse
// this block.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   clr  : holds the divider at 0; the first tick comes DIV clocks after release
//   tick : one-cycle pulse at the oversample rate
module uart_baud_tick
  import uart_rx_oversampled_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUDRATE   = DEF_BAUDRATE,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = baud_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV - 1));
  assign tick = wrap & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || wrap) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART receiver: 8N1 framing, LSB first, 16x oversampling.
// rx_in passes through a 2-flop synchroniser. Start bits are re-checked at
// mid-bit to reject glitches. Data and stop bits are sampled once per bit
// period, in the middle of the bit. Bytes are handed downstream on a
// valid/ready interface.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   rx_in     : serial line, idle high, asynchronous to clk
//   d_out     : received byte; stable while d_valid is high
//   d_valid   : byte available; held until it is accepted
//   d_ready   : consumer accepts the byte when d_valid & d_ready
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a byte completes while the previous
//               byte is still unaccepted; the new byte is dropped
//   busy      : high while a frame is in progress
module uart_rx_oversampled
  import uart_rx_oversampled_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUDRATE   = DEF_BAUDRATE,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  // Synchroniser. Both flops reset to the idle level so that leaving reset
  // does not look like a start edge.
  logic rx_m, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // Tick divider. It is held clear in IDLE, so every frame's tick phase is
  // aligned to the detected start edge.
  rx_state_t state, state_d;
  logic      tick, tick_clr;

  assign tick_clr = (state == ST_IDLE);

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUDRATE  (BAUDRATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  // FSM and datapath counters
  logic [TW-1:0]        tcnt, tcnt_d;
  logic [BW-1:0]        bcnt, bcnt_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 deliver, stop_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      state <= state_d;
      tcnt  <= tcnt_d;
      bcnt  <= bcnt_d;
      shreg <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state;
    tcnt_d   = tcnt;
    bcnt_d   = bcnt;
    shreg_d  = shreg;
    deliver  = 1'b0;
    stop_bad = 1'b0;

    if (tick) tcnt_d = (tcnt == T_LAST) ? '0 : tcnt + 1'b1;

    case (state)
      ST_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        // Confirm the start bit at its centre. A high line here means the
        // edge was a glitch.
        if (tick && tcnt == T_HALF) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
      end
      ST_DATA: begin
        // Counting resumes from mid-start, so each full tick period lands
        // in the middle of the next bit.
        if (tick && tcnt == T_LAST) begin
          shreg_d = {rx_s, shreg[DATA_BITS-1:1]};
          bcnt_d  = bcnt + 1'b1;
          if (bcnt == B_LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick && tcnt == T_LAST) begin
          if (rx_s) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        // After a framing error, do not rearm until the line returns high.
        // Otherwise a held break would be decoded as a string of 0x00 frames.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Output register and handshake
  logic accept;
  assign accept = d_valid & d_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out     <= '0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver) begin
        // If the slot frees in this same cycle, the new byte replaces the
        // accepted one without a gap in d_valid.
        if (!d_valid || accept) begin
          d_out   <= shreg;
          d_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        d_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  localparam int BIT = 432;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] d_out;
  logic       d_valid;
  logic       d_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_oversampled dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .d_out    (d_out),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Passive monitor. Sampled on the falling edge; inputs change just after
  // the rising edge.
  logic [7:0] got[$];
  int vld_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (d_valid && d_ready) got.push_back(d_out);
      if (d_valid)   vld_cyc  = vld_cyc + 1;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun)   ovr_cnt  = ovr_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, the first nbits data bits (LSB first), and, when all eight
  // data bits are sent, the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stopv, input int nbits);
    rx_in = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_in = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (nbits == 8) begin
      rx_in = stopv;
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int g0, v0, f0, o0;

  task automatic snap();
    g0 = got.size();
    v0 = vld_cyc;
    f0 = ferr_cnt;
    o0 = ovr_cnt;
  endtask

  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    d_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_d_out", d_out, 8'h00);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    idle(10);

    // 1: single byte with the consumer ready
    snap();
    send_frame(8'hA5, 1'b1, 8);
    idle(BIT);
    chk("t1_count", got.size() - g0, 1);
    if (got.size() > g0) chk("t1_byte", got[g0], 8'hA5);
    chk("t1_vld_cycles", vld_cyc - v0, 1);
    chk("t1_ferr", ferr_cnt - f0, 0);
    chk("t1_ovr", ovr_cnt - o0, 0);
    chk("t1_busy", busy, 0);

    // 2: 100-clock low glitch is rejected at the start-bit centre
    snap();
    rx_in = 1'b0;
    repeat (100) @(negedge clk);
    chk("t2_busy_mid", busy, 1);
    rx_in = 1'b1;
    repeat (120) @(negedge clk);
    chk("t2_busy_end", busy, 0);
    idle(BIT);
    chk("t2_vld", vld_cyc - v0, 0);
    chk("t2_ferr", ferr_cnt - f0, 0);

    // 3: framing error, then recovery
    snap();
    send_frame(8'h3C, 1'b0, 8);
    idle(2 * BIT);
    chk("t3_ferr", ferr_cnt - f0, 1);
    chk("t3_no_vld", vld_cyc - v0, 0);
    snap();
    send_frame(8'h55, 1'b1, 8);
    idle(BIT);
    chk("t3_count", got.size() - g0, 1);
    chk("t3_d_out", d_out, 8'h55);

    // 4: overrun while the consumer is stalled
    @(posedge clk); #1 d_ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, 8);
    send_frame(8'h22, 1'b1, 8);
    idle(BIT);
    chk("t4_valid_held", d_valid, 1);
    chk("t4_d_out", d_out, 8'h11);
    chk("t4_ovr", ovr_cnt - o0, 1);
    chk("t4_none_taken", got.size() - g0, 0);
    @(posedge clk); #1 d_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_valid_drop", d_valid, 0);
    chk("t4_accepted", got.size() - g0, 1);
    if (got.size() > g0) chk("t4_acc_byte", got[g0], 8'h11);

    // 5: reset in the middle of a frame
    snap();
    send_frame(8'hC3, 1'b1, 4);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_d_out", d_out, 8'h00);
    chk("t5_d_valid", d_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ferr", frame_err, 0);
    chk("t5_ovr", overrun, 0);
    rst = 1'b0;
    idle(10);
    send_frame(8'h7E, 1'b1, 8);
    idle(BIT);
    chk("t5_count", got.size() - g0, 1);
    if (got.size() > g0) chk("t5_byte", got[g0], 8'h7E);

    // 6: back-to-back frames with no idle gap
    snap();
    send_frame(8'h00, 1'b1, 8);
    send_frame(8'hFF, 1'b1, 8);
    send_frame(8'h81, 1'b1, 8);
    idle(BIT);
    chk("t6_count", got.size() - g0, 3);
    if (got.size() >= g0 + 3) begin
      chk("t6_b0", got[g0], 8'h00);
      chk("t6_b1", got[g0+1], 8'hFF);
      chk("t6_b2", got[g0+2], 8'h81);
    end
    chk("t6_ferr", ferr_cnt - f0, 0);
    chk("t6_ovr", ovr_cnt - o0, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
